// File: rtl/riscv_pkg.sv
// riscv_pkg: shared constants for the fetch stage (FSM states, branch codes, flags, traps).
// Revision 1.0
`default_nettype none

package riscv_pkg;

  localparam logic [2:0] ST_RESET = 3'd0;
  localparam logic [2:0] ST_REQ   = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_EXEC  = 3'd3;
  localparam logic [2:0] ST_HALT  = 3'd4;

  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLT  = 3'b100;
  localparam logic [2:0] BR_BGE  = 3'b101;
  localparam logic [2:0] BR_BLTU = 3'b110;
  localparam logic [2:0] BR_BGEU = 3'b111;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam logic [1:0] TRAP_NONE      = 2'b00;
  localparam logic [1:0] TRAP_MISALIGN  = 2'b01;
  localparam logic [1:0] TRAP_TIMEOUT   = 2'b10;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

`default_nettype wire

// File: rtl/branch_resolve.sv
// branch_resolve: combinational branch decision from {is_branch, funct3} and {N,Z,C,V}.
// Revision 1.0
`default_nettype none

module branch_resolve
  import riscv_pkg::*;
(
  input  logic [3:0] branching_i,
  input  logic [3:0] alu_flag_i,
  output logic       taken_o
);

  logic cond;

  always_comb begin
    cond = 1'b0;
    case (branching_i[2:0])
      BR_BEQ:  cond = alu_flag_i[FLAG_Z];
      BR_BNE:  cond = ~alu_flag_i[FLAG_Z];
      BR_BLT:  cond = alu_flag_i[FLAG_N] ^ alu_flag_i[FLAG_V];
      BR_BGE:  cond = ~(alu_flag_i[FLAG_N] ^ alu_flag_i[FLAG_V]);
      BR_BLTU: cond = ~alu_flag_i[FLAG_C];
      BR_BGEU: cond = alu_flag_i[FLAG_C];
      default: cond = 1'b0;
    endcase
  end

  assign taken_o = branching_i[3] & cond;

endmodule

`default_nettype wire

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: PC register, req/rvalid instruction fetch and next-PC selection with traps.
// Revision 1.0
`default_nettype none

module fetch_pc_unit
  import riscv_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              MAX_WAIT = 255
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     instr,
  output logic            instr_valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  input  logic            jumping,
  input  logic            jalr,
  input  logic [3:0]      branching,
  input  logic [3:0]      alu_flag,
  input  logic [XLEN-1:0] imm_ext,
  input  logic [XLEN-1:0] alu_result,
  input  logic            stall,
  output logic            trap,
  output logic [1:0]      trap_cause,
  output logic [XLEN-1:0] trap_pc
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  logic [2:0]      state_q,   state_d;
  logic [XLEN-1:0] pc_q,      pc_d;
  logic [31:0]     instr_q,   instr_d;
  logic            trap_q,    trap_d;
  logic [1:0]      cause_q,   cause_d;
  logic [XLEN-1:0] trap_pc_q, trap_pc_d;
  logic [CW-1:0]   cnt_q,     cnt_d;

  logic            taken;
  logic [XLEN-1:0] next_pc;
  logic [CW-1:0]   cnt_inc;
  logic            unused_alu_lsb;

  branch_resolve u_branch_resolve (
    .branching_i (branching),
    .alu_flag_i  (alu_flag),
    .taken_o     (taken)
  );

  // jalr clears bit 0 of its target, so that bit is intentionally dropped
  assign unused_alu_lsb = alu_result[0];
  assign cnt_inc        = cnt_q + CW'(1);

  always_comb begin
    if (jumping && jalr) begin
      next_pc = {alu_result[XLEN-1:1], 1'b0};
    end else if (jumping || taken) begin
      next_pc = pc_q + imm_ext;
    end else begin
      next_pc = pc_q + XLEN'(4);
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    trap_d    = trap_q;
    cause_d   = cause_q;
    trap_pc_d = trap_pc_q;
    cnt_d     = cnt_q;
    case (state_q)
      ST_RESET: state_d = ST_REQ;
      ST_REQ: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // a response arriving on the last allowed cycle still beats the timeout
        if (imem_rvalid) begin
          instr_d = imem_rdata;
          state_d = ST_EXEC;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CW'(MAX_WAIT)) begin
            trap_d    = 1'b1;
            cause_d   = TRAP_TIMEOUT;
            trap_pc_d = pc_q;
            state_d   = ST_HALT;
          end
        end
      end
      ST_EXEC: begin
        if (!stall) begin
          if (next_pc[1:0] != 2'b00) begin
            trap_d    = 1'b1;
            cause_d   = TRAP_MISALIGN;
            trap_pc_d = pc_q;
            state_d   = ST_HALT;
          end else begin
            pc_d    = next_pc;
            state_d = ST_REQ;
          end
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_RESET;
      pc_q      <= RESET_PC;
      instr_q   <= NOP_INSTR;
      trap_q    <= 1'b0;
      cause_q   <= TRAP_NONE;
      trap_pc_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      trap_q    <= trap_d;
      cause_q   <= cause_d;
      trap_pc_q <= trap_pc_d;
      cnt_q     <= cnt_d;
    end
  end

  assign imem_req    = (state_q == ST_REQ);
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_valid = (state_q == ST_EXEC);
  assign pc          = pc_q;
  assign pc_plus4    = pc_q + XLEN'(4);
  assign trap        = trap_q;
  assign trap_cause  = cause_q;
  assign trap_pc     = trap_pc_q;

endmodule

`default_nettype wire
